// File: rtl/demux12_stream_if.sv
// rtl/demux12_stream_if.sv - input stream and two output streams of the 1:2 packet demux
interface demux12_stream_if #(
  parameter int W = 8
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_last;
  logic         s_sel;

  logic         m0_valid;
  logic         m0_ready;
  logic [W-1:0] m0_data;
  logic         m0_last;

  logic         m1_valid;
  logic         m1_ready;
  logic [W-1:0] m1_data;
  logic         m1_last;

  // master: producer of the input stream and consumer of both outputs
  modport master (
    output s_valid, s_data, s_last, s_sel, m0_ready, m1_ready,
    input  s_ready, m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last
  );

  // slave: the demux itself
  modport slave (
    input  s_valid, s_data, s_last, s_sel, m0_ready, m1_ready,
    output s_ready, m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last
  );
endinterface

// File: rtl/demux12_stream.sv
// rtl/demux12_stream.sv - 1:2 packet demux, route locked per packet, one-entry output slices
module demux12_stream #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demux12_stream_if.slave    bus,
  output logic [CNT_W-1:0]   pkt_cnt0,
  output logic [CNT_W-1:0]   pkt_cnt1
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;
  logic   lock_sel, lock_sel_nxt;
  logic   tgt, tgt_free, rdy, acc, load0, load1;

  // The first beat of a packet routes on s_sel directly; later beats use the locked copy.
  always_comb begin
    state_nxt    = state;
    lock_sel_nxt = lock_sel;
    tgt          = (state == BUSY) ? lock_sel : bus.s_sel;
    tgt_free     = tgt ? (~bus.m1_valid | bus.m1_ready) : (~bus.m0_valid | bus.m0_ready);
    rdy          = rst_n & tgt_free;
    acc          = bus.s_valid & rdy;
    load0        = acc & ~tgt;
    load1        = acc & tgt;
    if (acc) begin
      case (state)
        IDLE: begin
          if (!bus.s_last) begin
            state_nxt    = BUSY;
            lock_sel_nxt = bus.s_sel;
          end
        end
        BUSY: begin
          if (bus.s_last) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.s_ready = rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_sel <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_sel <= lock_sel_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m0_valid <= 1'b0;
      bus.m0_data  <= '0;
      bus.m0_last  <= 1'b0;
    end else if (load0) begin
      bus.m0_valid <= 1'b1;
      bus.m0_data  <= bus.s_data;
      bus.m0_last  <= bus.s_last;
    end else if (bus.m0_valid && bus.m0_ready) begin
      bus.m0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m1_valid <= 1'b0;
      bus.m1_data  <= '0;
      bus.m1_last  <= 1'b0;
    end else if (load1) begin
      bus.m1_valid <= 1'b1;
      bus.m1_data  <= bus.s_data;
      bus.m1_last  <= bus.s_last;
    end else if (bus.m1_valid && bus.m1_ready) begin
      bus.m1_valid <= 1'b0;
    end
  end

  // Counters wrap silently; a packet counts when its last beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (acc && bus.s_last) begin
      if (tgt) pkt_cnt1 <= pkt_cnt1 + CNT_ONE;
      else     pkt_cnt0 <= pkt_cnt0 + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_demux12_stream.sv
// tb/tb_demux12_stream.sv - directed scoreboard bench for demux12_stream
module tb_demux12_stream;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pkt_cnt0, pkt_cnt1;

  demux12_stream_if #(.W(8)) bus ();

  demux12_stream #(.W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1)
  );

  always #5 clk = ~clk;

  int         vec  = 0;
  int         miss = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] e0 = 8'd0;
  logic [7:0] e1 = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one cycle; expected beats go to the scoreboard of the port they must reach.
  task automatic send(input logic [7:0] d, input logic sel, input logic last,
                      input logic port, input logic exp_rdy);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_sel   = sel;
    bus.s_last  = last;
    @(negedge clk);
    chk("s_ready", {31'd0, bus.s_ready}, {31'd0, exp_rdy});
    if (exp_rdy) begin
      if (port) begin
        q1.push_back({last, d});
        if (last) e1 = e1 + 8'd1;
      end else begin
        q0.push_back({last, d});
        if (last) e0 = e0 + 8'd1;
      end
    end
    tick();
  endtask

  task automatic quiet_neg();
    bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  // Output monitor: every completed output transfer must match the scoreboard head.
  always @(negedge clk) begin
    if (bus.m0_valid && bus.m0_ready) begin
      if (q0.size() == 0) chk("m0_unexpected", 32'd1, 32'd0);
      else chk("m0_beat", {23'd0, bus.m0_last, bus.m0_data}, {23'd0, q0.pop_front()});
    end
    if (bus.m1_valid && bus.m1_ready) begin
      if (q1.size() == 0) chk("m1_unexpected", 32'd1, 32'd0);
      else chk("m1_beat", {23'd0, bus.m1_last, bus.m1_data}, {23'd0, q1.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.s_valid  = 1'b1;
    bus.s_data   = 8'h5A;
    bus.s_sel    = 1'b0;
    bus.s_last   = 1'b1;
    bus.m0_ready = 1'b1;
    bus.m1_ready = 1'b1;

    // reset with s_valid held high
    tick();
    tick();
    @(negedge clk);
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("rst_m0_valid", {31'd0, bus.m0_valid}, 32'd0);
    chk("rst_m1_valid", {31'd0, bus.m1_valid}, 32'd0);
    chk("rst_cnt0", {24'd0, pkt_cnt0}, 32'd0);
    chk("rst_cnt1", {24'd0, pkt_cnt1}, 32'd0);
    bus.s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_s_ready", {31'd0, bus.s_ready}, 32'd1);
    tick();

    // single-beat packet to port 1
    send(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    quiet_neg();
    chk("t2_m1_valid", {31'd0, bus.m1_valid}, 32'd1);
    chk("t2_m1_data", {24'd0, bus.m1_data}, 32'hA5);
    chk("t2_m1_last", {31'd0, bus.m1_last}, 32'd1);
    chk("t2_m0_valid", {31'd0, bus.m0_valid}, 32'd0);
    chk("t2_cnt1", {24'd0, pkt_cnt1}, 32'd1);
    chk("t2_cnt0", {24'd0, pkt_cnt0}, 32'd0);
    tick();

    // route lock: s_sel changes mid-packet but beats stay on m0
    send(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h33, 1'b1, 1'b1, 1'b0, 1'b1);
    send(8'h44, 1'b1, 1'b1, 1'b1, 1'b1);
    quiet_neg();
    chk("t3_cnt0", {24'd0, pkt_cnt0}, 32'd1);
    chk("t3_m1_data", {24'd0, bus.m1_data}, 32'h44);
    tick();

    // backpressure on m0, isolation of m1
    bus.m0_ready = 1'b0;
    send(8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
    send(8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_m0_hold", {24'd0, bus.m0_data}, 32'h01);
    send(8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
    quiet_neg();
    chk("t4_m1_data", {24'd0, bus.m1_data}, 32'h03);
    chk("t4_m0_data", {24'd0, bus.m0_data}, 32'h01);
    chk("t4_m0_valid", {31'd0, bus.m0_valid}, 32'd1);
    tick();
    bus.m0_ready = 1'b1;
    send(8'h04, 1'b0, 1'b1, 1'b0, 1'b1);
    quiet_neg();
    chk("t4_m0_new", {24'd0, bus.m0_data}, 32'h04);
    chk("t4_cnt0", {24'd0, pkt_cnt0}, {24'd0, e0});
    chk("t4_cnt1", {24'd0, pkt_cnt1}, {24'd0, e1});
    tick();

    // counter wrap after a fresh reset
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    e0 = 8'd0;
    e1 = 8'd0;
    for (int i = 0; i < 256; i++) begin
      send(i[7:0], 1'b0, 1'b1, 1'b0, 1'b1);
      chk("t5_nobubble", {31'd0, bus.m0_valid}, 32'd1);
      if (i == 254) chk("t5_cnt255", {24'd0, pkt_cnt0}, 32'd255);
      if (i == 255) chk("t5_cnt_wrap", {24'd0, pkt_cnt0}, 32'd0);
    end
    quiet_neg();
    tick();

    // asynchronous reset in the middle of a packet to port 1
    bus.m1_ready = 1'b0;
    send(8'hB1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t6_m1_pre", {31'd0, bus.m1_valid}, 32'd1);
    bus.s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_m1_drop", {31'd0, bus.m1_valid}, 32'd0);
    chk("t6_cnt1", {24'd0, pkt_cnt1}, 32'd0);
    q0.delete();
    q1.delete();
    e0 = 8'd0;
    e1 = 8'd0;
    tick();
    rst_n = 1'b1;
    bus.m1_ready = 1'b1;
    send(8'hC0, 1'b0, 1'b1, 1'b0, 1'b1);
    quiet_neg();
    chk("t6_m0_valid", {31'd0, bus.m0_valid}, 32'd1);
    chk("t6_m0_data", {24'd0, bus.m0_data}, 32'hC0);
    chk("t6_m1_valid", {31'd0, bus.m1_valid}, 32'd0);
    chk("t6_cnt0", {24'd0, pkt_cnt0}, 32'd1);
    tick();
    tick();

    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/demux12_stream.md
# demux12_stream

Valid/ready stream demultiplexer that routes one input packet stream to one of two output streams. It is the receive-side counterpart of the 2:1 select path. Routing is chosen by `s_sel` on the first beat of each packet and held for the whole packet. Each output has a one-entry registered slice. The block sits between a single producer and two downstream consumers in the simulation datapath.

## Interface
- `W`, default 8: data width in bits.
- `CNT_W`, default 8: width of each per-port packet counter.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `s_valid` input 1: input beat valid.
- `s_ready` output 1: input beat accepted when `s_valid & s_ready`.
- `s_data` input W: input beat data.
- `s_last` input 1: last beat of the packet.
- `s_sel` input 1: destination port (0 → m0, 1 → m1). Sampled only on the first beat of a packet.
- `m0_valid`, `m1_valid` output 1: output beat valid.
- `m0_ready`, `m1_ready` input 1: downstream ready.
- `m0_data`, `m1_data` output W: output beat data.
- `m0_last`, `m1_last` output 1: output last flag.
- `pkt_cnt0`, `pkt_cnt1` output CNT_W: completed packets routed to each port.

## Operation
- **State machine**, two states:
  - IDLE: no packet in progress. Target `t = s_sel`.
  - BUSY: packet in progress. Target `t = lock_sel`, a register captured on the first beat.
- **Transitions** (on an accepted beat only):
  - IDLE with `s_last = 0` → BUSY, and `lock_sel <= s_sel`.
  - IDLE with `s_last = 1` → stays IDLE (single-beat packet).
  - BUSY with `s_last = 1` → IDLE.
  - BUSY with `s_last = 0` → stays BUSY.
  - No accepted beat: state unchanged.
- In BUSY, `s_sel` is ignored.
- **Output slice per port p**: one register holding {valid, data, last}.
  - The slice loads when an input beat is accepted with `t = p`.
  - The slice clears when `mp_valid & mp_ready` and no new load occurs that cycle.
  - Load and drain in the same cycle: the slice takes the new beat and valid stays 1.
- **Ready**: `s_ready = rst_n & (~mp_valid | mp_ready)`, evaluated for `p = t`.
  - This is a combinational path from `mX_ready`, and in IDLE also from `s_sel`, to `s_ready`.
  - The producer must hold `s_data`, `s_sel` and `s_last` stable while `s_valid` is high and `s_ready` is low.
- **Isolation**: the non-target port is never loaded. A full slice on the non-target port does not block the input.
- **Counters**: `pkt_cnt[t]` increments by 1 when a beat with `s_last = 1` is accepted.
  - Counting is modulo 2^CNT_W; the counter wraps from all-ones to 0 with no saturation and no flag.
- **Output stability**: while `mp_valid = 1` and `mp_ready = 0`, `mp_data` and `mp_last` hold their values.

## Timing
- **Reset** (asynchronous, effective immediately on `rst_n` low):
  - state = IDLE, `lock_sel` = 0.
  - `m0_valid`/`m1_valid` = 0, `m0_data`/`m1_data` = 0, `m0_last`/`m1_last` = 0.
  - `pkt_cnt0`/`pkt_cnt1` = 0.
  - `s_ready` = 0 while `rst_n` is low.
  - Reset mid-packet discards the partial packet and any buffered beats; that packet is not counted.
- **First cycle after release**: `s_ready` = 1, since both slices are empty.
- **Latency**: a beat accepted at edge N appears on `mp_valid`/`mp_data` after edge N, i.e. 1 cycle.
- **Throughput**: 1 beat per cycle per packet while the target `mp_ready` = 1.
- **Counter update**: visible the cycle after the last beat is accepted, the same cycle the beat appears at the output.

## Test plan
1. **Reset**: hold `rst_n` = 0 with `s_valid` = 1.
   - During reset: `s_ready` = 0, all `m*_valid` = 0, counters = 0.
   - After release: `s_ready` = 1.
2. **Single-beat packet to port 1**: `s_sel` = 1, `s_data` = 0xA5, `s_last` = 1, `m1_ready` = 1.
   - Next cycle: `m1_valid` = 1, `m1_data` = 0xA5, `m1_last` = 1.
   - `m0_valid` stays 0. `pkt_cnt1` = 1, `pkt_cnt0` = 0.
3. **Route lock**: 3-beat packet 0x11/0x22/0x33 with `s_sel` = 0 on beat 1 and `s_sel` = 1 on beats 2–3.
   - All three beats appear on m0 in order; last = 1 only on 0x33.
   - `pkt_cnt0` = 1. A following beat with `s_sel` = 1 goes to m1.
4. **Backpressure and isolation**: `m0_ready` = 0; send 0x01 (sel 0, last) then 0x02 (sel 0, last).
   - 0x01 is held on `m0_data`; `s_ready` = 0 for 0x02.
   - Switch the pending beat to 0x03 with sel 1: it is accepted, and `m1_data` = 0x03 while `m0_data` stays 0x01.
   - Raise `m0_ready` with 0x04 (sel 0) presented in the same cycle: both transfers occur and `m0_data` = 0x04 next cycle.
5. **Counter wrap**: 256 back-to-back single-beat packets to port 0 with `CNT_W` = 8.
   - `pkt_cnt0` reads 255 after 255 packets and 0 after the 256th.
   - 256 outputs, one per cycle, with no bubbles.
6. **Reset mid-packet**: assert `rst_n` low asynchronously after beat 1 of a 3-beat packet to port 1.
   - `m1_valid` drops without waiting for a clock edge; `pkt_cnt1` = 0.
   - After release, a beat with `s_sel` = 0 is routed to m0 (state is IDLE).
